// File: rtl/mips_mem_pkg.sv
// Shared encodings for the instruction/data memory arbiter.
package mips_mem_pkg;

    // Arbiter transaction phases.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Which requester owns the current memory transaction.
    typedef enum logic {
        OWN_FETCH = 1'b0,
        OWN_DATA  = 1'b1
    } owner_t;

    // Byte enable for a full-word access (all instruction fetches).
    localparam logic [3:0] BE_FULL = 4'hF;

endpackage : mips_mem_pkg

// File: rtl/mem_arb_prio.sv
// Winner selection between fetch and data, with a saturating starvation
// counter that forces a fetch grant after STARVE_MAX data grants in a row
// while fetch was waiting.
module mem_arb_prio
    import mips_mem_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   i_req,
    input  logic   d_req,
    input  logic   grant,
    output owner_t winner
);

    localparam int CW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(STARVE_MAX);

    logic [CW-1:0] starve_cnt;

    // Data wins by default; fetch wins alone or once it has starved long enough.
    always_comb begin
        // NOTE: assigning a default first keeps every path driven, so no latch is inferred.
        winner = OWN_FETCH;
        if (d_req && !(i_req && (starve_cnt == CNT_MAX))) begin
            winner = OWN_DATA;
        end
    end

    // Count data grants taken while fetch waits; any fetch grant clears it.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            starve_cnt <= '0;
        end else if (grant) begin
            if (winner == OWN_FETCH) begin
                starve_cnt <= '0;
            end else if (i_req && (starve_cnt != CNT_MAX)) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
        end
    end

endmodule : mem_arb_prio

// File: rtl/mem_arbiter.sv
// Serialises instruction-fetch and data accesses onto one single-ported
// memory bus with request/ready handshakes and per-stage stall outputs.
module mem_arbiter
    import mips_mem_pkg::*;
#(
    parameter int STARVE_MAX = 4,
    parameter int AW         = 32,
    parameter int DW         = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic [DW-1:0] i_rdata,
    output logic          i_ready,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [3:0]    d_be,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic [DW-1:0] d_rdata,
    output logic          d_ready,
    output logic          m_req,
    output logic          m_we,
    output logic [3:0]    m_be,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    input  logic          m_ack,
    input  logic [DW-1:0] m_rdata,
    output logic          stall_if,
    output logic          stall_me
);

    state_t state, state_nxt;
    owner_t owner, winner;
    logic   grant;

    // A grant happens only from IDLE; RESP never re-arbitrates.
    assign grant = (state == ST_IDLE) && (i_req || d_req);

    mem_arb_prio #(
        .STARVE_MAX(STARVE_MAX)
    ) u_prio (
        .clk    (clk),
        .reset  (reset),
        .i_req  (i_req),
        .d_req  (d_req),
        .grant  (grant),
        .winner (winner)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: IDLE -> BUSY on any request, BUSY -> RESP on ack, RESP -> IDLE.
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: if (i_req || d_req) state_nxt = ST_BUSY;
            ST_BUSY: if (m_ack)          state_nxt = ST_RESP;
            ST_RESP:                     state_nxt = ST_IDLE;
            default:                     state_nxt = ST_IDLE;
        endcase
    end

    // Latch the winner's payload on grant; held stable for the whole transaction.
    always_ff @(posedge clk) begin
        if (reset) begin
            owner   <= OWN_FETCH;
            m_we    <= 1'b0;
            m_be    <= '0;
            m_addr  <= '0;
            m_wdata <= '0;
        end else if (grant) begin
            owner <= winner;
            if (winner == OWN_DATA) begin
                m_we    <= d_we;
                m_be    <= d_be;
                m_addr  <= d_addr;
                m_wdata <= d_wdata;
            end else begin
                m_we    <= 1'b0;
                m_be    <= BE_FULL;
                m_addr  <= i_addr;
                m_wdata <= '0;
            end
        end
    end

    // Capture memory read data into the owner's register on ack (stores included).
    always_ff @(posedge clk) begin
        if (reset) begin
            i_rdata <= '0;
            d_rdata <= '0;
        end else if ((state == ST_BUSY) && m_ack) begin
            if (owner == OWN_FETCH) begin
                i_rdata <= m_rdata;
            end else begin
                d_rdata <= m_rdata;
            end
        end
    end

    // Bus request and ready pulses decode registered state only.
    assign m_req   = (state == ST_BUSY);
    assign i_ready = (state == ST_RESP) && (owner == OWN_FETCH);
    assign d_ready = (state == ST_RESP) && (owner == OWN_DATA);

    // Stalls are the only combinational input-to-output paths.
    assign stall_if = i_req & ~i_ready;
    assign stall_me = d_req & ~d_ready;

endmodule : mem_arbiter
